// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a registered-output FIFO and serialises each
// word as a start bit, WIDTH data bits (LSB first) and STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             empty,
    input  logic [WIDTH-1:0] pop_data,
    output logic             pop_en,
    output logic             tx,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [WIDTH-1:0] shift, shift_nx;
    logic             tx_nx;
    logic             bit_done;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shift_nx = shift;
        bit_done = (cnt == CNT_MAX);

        case (state)
            IDLE:  if (!empty) state_nx = FETCH;
            FETCH: state_nx = LOAD;
            LOAD: begin
                shift_nx = pop_data;
                cnt_nx   = '0;
                idx_nx   = '0;
                state_nx = START;
            end
            START, DATA, STOP: begin
                cnt_nx = bit_done ? '0 : cnt + CW'(1);
                if (bit_done) begin
                    if (state == START) begin
                        idx_nx   = '0;
                        state_nx = DATA;
                    end else if (state == DATA) begin
                        shift_nx = shift >> 1;
                        if (idx == DATA_LAST) begin
                            idx_nx   = '0;
                            state_nx = STOP;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end else begin
                        // Only the end of the final stop bit looks at empty.
                        if (idx == STOP_LAST) begin
                            idx_nx   = '0;
                            state_nx = empty ? IDLE : FETCH;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            pop_en <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shift  <= shift_nx;
            tx     <= tx_nx;
            busy   <= (state_nx != IDLE);
            pop_en <= (state_nx == LOAD);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations fed by a registered FIFO model,
// with a per-instance line monitor checking frames against a scoreboard.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    typedef struct {
        logic [11:0] bits;   // frame in line order, bit 0 = start bit
        int          gap;    // required idle-high cycles before it, -1 = any
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n_v    [3];
    logic       empty_r    [3];
    logic [7:0] pop_data_r [3];
    logic       pop_en_w   [3];
    logic       tx_w       [3];
    logic       busy_w     [3];

    logic [7:0] fq   [3][$];
    frame_t     expq [3][$];
    int         pops [3];
    bit         abort[3];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .WIDTH(8)) u0 (
        .clk(clk), .rst_n(rst_n_v[0]), .empty(empty_r[0]), .pop_data(pop_data_r[0][7:0]),
        .pop_en(pop_en_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .WIDTH(7)) u1 (
        .clk(clk), .rst_n(rst_n_v[1]), .empty(empty_r[1]), .pop_data(pop_data_r[1][6:0]),
        .pop_en(pop_en_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(5), .STOP_BITS(1), .WIDTH(8)) u2 (
        .clk(clk), .rst_n(rst_n_v[2]), .empty(empty_r[2]), .pop_data(pop_data_r[2][7:0]),
        .pop_en(pop_en_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Registered FIFO: pushes show up on empty/pop_data at the next edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pop_en_w[i]) begin
                check($sformatf("u%0d_pop_while_empty", i), int'(empty_r[i]), 0);
                if (fq[i].size() != 0) begin
                    fq[i].delete(0);
                    pops[i]++;
                end
            end
            empty_r[i]    <= (fq[i].size() == 0);
            pop_data_r[i] <= (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    end

    task automatic monitor(input int i, input int clks, input int nbits);
        logic   prev    = 1'b1;
        int     cyc     = 0;
        int     end_cyc = -1000;
        int     bad;
        bit     aborted;
        frame_t f;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n_v[i] === 1'b1 && prev === 1'b1 && tx_w[i] === 1'b0) begin
                if (expq[i].size() == 0) begin
                    check($sformatf("u%0d_unexpected_frame", i), 1, 0);
                end else begin
                    f = expq[i].pop_front();
                    if (f.gap >= 0)
                        check($sformatf("u%0d_gap", i), cyc - end_cyc, f.gap);
                    aborted = 1'b0;
                    for (int k = 0; k < nbits && !aborted; k++) begin
                        bad = 0;
                        for (int c = 0; c < clks && !aborted; c++) begin
                            if (k != 0 || c != 0) begin
                                @(negedge clk);
                                cyc++;
                            end
                            if (abort[i]) aborted = 1'b1;
                            else if (tx_w[i] !== f.bits[k]) bad++;
                        end
                        if (!aborted)
                            check($sformatf("u%0d_bit%0d_bad_cycles", i, k), bad, 0);
                    end
                    if (aborted) abort[i] = 1'b0;
                    end_cyc = cyc + 1;
                end
            end
            prev = tx_w[i];
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic [11:0] bits, input int gap);
        fq[i].push_back(d);
        expq[i].push_back('{bits: bits, gap: gap});
    endtask

    task automatic wait_tx_low(input int i);
        int n = 0;
        while (tx_w[i] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_start_seen", i), int'(tx_w[i]), 0);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((busy_w[i] !== 1'b0 || empty_r[i] !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_idle_reached", i), int'(busy_w[i]), 0);
    endtask

    task automatic frame_len(input int i, input int exp_len);
        int n = 0;
        while (busy_w[i] === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_frame_len", i), n, exp_len);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i]    = 1'b0;
            empty_r[i]    = 1'b1;
            pop_data_r[i] = 8'h00;
            pops[i]       = 0;
            abort[i]      = 1'b0;
        end
        fork
            monitor(0, 4, 10);
            monitor(1, 4, 10);
            monitor(2, 5, 10);
        join_none

        // Reset held with a non-empty FIFO: nothing may move.
        @(negedge clk);
        push(0, 8'hA5, 12'b0011_0100_1010, -1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_tx", int'(tx_w[0]), 1);
            check("rst_pop_en", int'(pop_en_w[0]), 0);
            check("rst_busy", int'(busy_w[0]), 0);
        end
        for (int i = 0; i < 3; i++) rst_n_v[i] = 1'b1;

        // Single byte 0xA5.
        wait_tx_low(0);
        wait_idle(0);
        check("single_pops", pops[0], 1);

        // Burst of three back-to-back bytes.
        push(0, 8'h00, 12'b0010_0000_0000, -1);
        push(0, 8'hFF, 12'b0011_1111_1110, 2);
        push(0, 8'h3C, 12'b0010_0111_1000, 2);
        wait_tx_low(0);
        wait_idle(0);
        check("burst_pops", pops[0], 4);
        check("burst_empty", int'(empty_r[0]), 1);

        // Reset during data bit 3; the following byte must still go out intact.
        push(0, 8'h5A, 12'b0010_1011_0100, -1);
        push(0, 8'hC3, 12'b0011_1000_0110, -1);
        wait_tx_low(0);
        repeat (17) @(negedge clk);
        abort[0]   = 1'b1;
        rst_n_v[0] = 1'b0;
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        check("midrst_tx", int'(tx_w[0]), 1);
        check("midrst_pop_en", int'(pop_en_w[0]), 0);
        check("midrst_busy", int'(busy_w[0]), 0);
        wait_tx_low(0);
        wait_idle(0);
        check("midrst_pops", pops[0], 6);

        // WIDTH=7 with two stop bits: 40-cycle frame.
        push(1, 8'h55, 12'b0011_1010_1010, -1);
        wait_tx_low(1);
        frame_len(1, 40);
        check("u1_pops", pops[1], 1);

        // Non-power-of-2 baud, with the IDLE->FETCH->LOAD->START latency.
        push(2, 8'h81, 12'b0011_0000_0010, -1);
        @(negedge clk);
        check("lat_n_empty", int'(empty_r[2]), 0);
        check("lat_n_busy", int'(busy_w[2]), 0);
        @(negedge clk);
        check("lat_fetch_busy", int'(busy_w[2]), 1);
        check("lat_fetch_pop_en", int'(pop_en_w[2]), 0);
        @(negedge clk);
        check("lat_load_pop_en", int'(pop_en_w[2]), 1);
        check("lat_load_tx", int'(tx_w[2]), 1);
        @(negedge clk);
        check("lat_start_tx", int'(tx_w[2]), 0);
        check("lat_start_pop_en", int'(pop_en_w[2]), 0);
        frame_len(2, 50);
        check("u2_pops", pops[2], 1);

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d_frames_left", i), expq[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
